// File: rtl/gb_pkg.sv
// Shared types and defaults for the global-buffer write arbiter.
package gb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONF    = 2'b01,
        ST_WRITE   = 2'b11,
        ST_RELEASE = 2'b10
    } gb_state_e;

    localparam int GB_NUM_REQ = 16;
    localparam int GB_ADDR_W  = 9;
    localparam int GB_ID_W    = $clog2(GB_NUM_REQ);

    // A single requester still needs a 1-bit id port.
    function automatic int gb_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gb_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module gb_rr_pick #(
    parameter int NUM_REQ = 16,
    parameter int ID_W    = 4
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] cand;

    // Scan farthest offset first so the nearest eligible index is the last one written.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (eligible[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/gb_wr_arb.sv
// Round-robin arbiter granting one SRAM bank at a time a full-burst write.
// Handshakes: a transfer occurs on a cycle where valid and ready are both high;
// conf_val/wr_rdy come from registered state only and never wait on the other side.
module gb_wr_arb
    import gb_pkg::*;
#(
    parameter  int NUM_REQ = GB_NUM_REQ,
    parameter  int ADDR_W  = GB_ADDR_W,
    localparam int ID_W    = gb_id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_en,
    output logic               conf_val,
    input  logic               conf_rdy,
    input  logic               wr_val,
    output logic               wr_rdy,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ID_W-1:0]    gnt_id,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output gb_state_e          state_dbg
);

    localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);

    gb_state_e          state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d, gnt_d, pick_idx;
    logic [NUM_REQ-1:0] served_q, served_d, eligible;
    logic [ADDR_W-1:0]  addr_d;
    logic               pick_val;

    assign eligible  = req & req_en & ~served_q;
    assign state_dbg = state_q;

    gb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .valid    (pick_val),
        .index    (pick_idx)
    );

    always_comb begin
        conf_val = (state_q == ST_CONF);
        wr_rdy   = (state_q == ST_WRITE);
        wr_en    = (state_q == ST_WRITE) && wr_val;
        busy     = (state_q != ST_IDLE);
        done     = '0;
        if (state_q == ST_RELEASE) done[gnt_id] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = wr_addr;
        ptr_d    = ptr_q;
        served_d = served_q;
        gnt_d    = gnt_id;
        case (state_q)
            ST_IDLE: begin
                // The one-cycle mask from RELEASE has done its job after this cycle.
                served_d = '0;
                if (pick_val) begin
                    gnt_d   = pick_idx;
                    state_d = ST_CONF;
                end
            end
            ST_CONF: begin
                if (conf_rdy) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_en) begin
                    addr_d = wr_addr + 1'b1;
                    if (&wr_addr) state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ptr_d            = gnt_id;
                served_d         = '0;
                served_d[gnt_id] = 1'b1;
                addr_d           = '0;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Restart overrides everything, including a grant decided this cycle.
        if (cfg_start) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            ptr_d    = PTR_INIT;
            served_d = '0;
            gnt_d    = gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_addr  <= '0;
            gnt_id   <= '0;
            ptr_q    <= PTR_INIT;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_addr  <= addr_d;
            gnt_id   <= gnt_d;
            ptr_q    <= ptr_d;
            served_q <= served_d;
        end
    end

endmodule

// File: tb/tb_gb_wr_arb.sv
// Randomized and directed bench for gb_wr_arb against a burst-level behavioural model.
module tb_gb_wr_arb;
    import gb_pkg::*;

    localparam int N     = 16;
    localparam int AW    = 9;
    localparam int IW    = 4;
    localparam int BURST = 512;

    logic          clk = 1'b0;
    logic          rst_n, cfg_start, conf_rdy, wr_val;
    logic [N-1:0]  req, req_en;
    logic          conf_val, wr_rdy, wr_en, busy;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] gnt_id;
    logic [N-1:0]  done;
    gb_state_e     state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // model: 0 idle, 1 waiting for conf_rdy, 2 streaming beats, 3 finishing
    int m_phase, m_beats, m_gnt, m_last, m_masked;
    logic [IW-1:0] exp_q[$];
    int grant_log[$];

    int cyc, n_wr_en, done_cnt, done_cyc, done_wr_cnt, grant_cyc;
    logic [N-1:0] done_vec;
    logic conf_seen;

    always #5 clk = ~clk;

    gb_wr_arb #(.NUM_REQ(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .req       (req),
        .req_en    (req_en),
        .conf_val  (conf_val),
        .conf_rdy  (conf_rdy),
        .wr_val    (wr_val),
        .wr_rdy    (wr_rdy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .gnt_id    (gnt_id),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] phase_code(input int p);
        case (p)
            1:       return 2'b01;
            2:       return 2'b11;
            3:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset(input bit keep_gnt);
        m_phase  = 0;
        m_beats  = 0;
        m_last   = N - 1;
        m_masked = -1;
        if (!keep_gnt) m_gnt = 0;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        logic [N-1:0] elig;
        logic [N-1:0] exp_done;
        int b;
        @(negedge clk);
        cyc++;
        exp_done = (m_phase == 3) ? (16'(1) << m_gnt) : '0;
        check("busy",     32'(busy),     32'(m_phase != 0));
        check("conf_val", 32'(conf_val), 32'(m_phase == 1));
        check("wr_rdy",   32'(wr_rdy),   32'(m_phase == 2));
        check("wr_en",    32'(wr_en),    32'(m_phase == 2 && wr_val));
        check("wr_addr",  32'(wr_addr),  32'(m_beats));
        check("done",     32'(done),     32'(exp_done));
        check("state",    32'(state_dbg), 32'(phase_code(m_phase)));
        if (m_phase != 0) check("gnt_id", 32'(gnt_id), 32'(m_gnt));
        if (conf_val && !conf_seen) begin
            if (exp_q.size() > 0) check("grant_order", 32'(gnt_id), 32'(exp_q.pop_front()));
            else                  check("grant_q_depth", 32'(exp_q.size()), 32'd1);
            grant_log.push_back(int'(gnt_id));
            grant_cyc = cyc;
        end
        if (wr_en) n_wr_en++;
        if (done != '0) begin
            done_cnt++;
            done_cyc    = cyc;
            done_vec    = done;
            done_wr_cnt = n_wr_en;
        end
        conf_seen = conf_val;

        if (!rst_n) begin
            model_reset(1'b0);
            exp_q.delete();
        end else if (cfg_start) begin
            model_reset(1'b1);
        end else begin
            case (m_phase)
                0: begin
                    elig = req & req_en;
                    if (m_masked >= 0) elig[m_masked] = 1'b0;
                    m_masked = -1;
                    for (int s = 1; s <= N; s++) begin
                        b = (m_last + s) % N;
                        if (elig[b]) begin
                            m_gnt   = b;
                            m_phase = 1;
                            exp_q.push_back(IW'(b));
                            break;
                        end
                    end
                end
                1: if (conf_rdy) m_phase = 2;
                2: if (wr_val) begin
                    if (m_beats == BURST - 1) begin
                        m_beats = 0;
                        m_phase = 3;
                    end else begin
                        m_beats++;
                    end
                end
                default: begin
                    m_last   = m_gnt;
                    m_masked = m_gnt;
                    m_phase  = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int start;
        int g;
        start = done_cnt;
        g = 0;
        while (done_cnt == start && g < bound) begin
            tick();
            g++;
        end
        if (done_cnt == start) check({tag, "_timeout"}, 32'(g), 32'(bound + 1));
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int g;
        g = 0;
        while (busy && g < bound) begin
            tick();
            g++;
        end
        if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_addr(input int addr, input int bound, input string tag);
        int g;
        g = 0;
        while (!(wr_rdy && int'(wr_addr) == addr) && g < bound) begin
            tick();
            g++;
        end
        check({tag, "_reach_addr"}, 32'(wr_addr), 32'(addr));
    endtask

    int exp_order[5] = '{0, 2, 15, 0, 2};
    int t_done, d0, g0;

    initial begin
        cyc = 0; n_wr_en = 0; done_cnt = 0; done_cyc = 0; done_wr_cnt = 0;
        grant_cyc = 0; done_vec = '0; conf_seen = 1'b0;
        rst_n = 1'b0; cfg_start = 1'b0; conf_rdy = 1'b0; wr_val = 1'b0;
        req = '0; req_en = '0;
        model_reset(1'b0);
        @(posedge clk);
        #1;

        // Reset holds everything quiet whatever the inputs do.
        for (int i = 0; i < 4; i++) begin
            req = N'($urandom); req_en = N'($urandom);
            conf_rdy = 1'($urandom); wr_val = 1'($urandom); cfg_start = 1'($urandom);
            tick();
        end

        // Single requester, full-speed burst: done lands on cycle 515.
        rst_n = 1'b1; cfg_start = 1'b0; req = 16'h0001; req_en = '1;
        conf_rdy = 1'b1; wr_val = 1'b1;
        cyc = 0; n_wr_en = 0;
        wait_done(600, "single");
        check("single_done_cycle", 32'(done_cyc), 32'd515);
        check("single_wr_count", 32'(done_wr_cnt), 32'd512);
        check("single_done_vec", 32'(done_vec), 32'h0001);
        req = '0;
        wait_idle(10, "single");

        // Restart pointer, then three requesters in rotation.
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        grant_log.delete();
        req = 16'h8005;
        begin
            int g;
            g = 0;
            while (grant_log.size() < 5 && g < 3000) begin
                tick();
                g++;
            end
        end
        check("rr_grant_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check($sformatf("rr_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        req = '0;
        wait_idle(700, "rr");

        // A lone requester is skipped for exactly one idle cycle after its done.
        req = 16'h0008;
        wait_done(1200, "mask");
        t_done = done_cyc;
        begin
            int g;
            g = 0;
            while (grant_cyc <= t_done && g < 10) begin
                tick();
                g++;
            end
        end
        check("mask_regrant_gap", 32'(grant_cyc - t_done), 32'd3);
        check("mask_regrant_id", 32'(gnt_id), 32'd3);
        req = '0;
        wait_idle(700, "mask");

        // Stalled configuration handshake.
        req = 16'h0010; conf_rdy = 1'b0; wr_val = 1'b1;
        n_wr_en = 0;
        for (int i = 0; i < 52; i++) tick();
        check("stall_no_wr", 32'(n_wr_en), 32'd0);
        check("stall_conf_val", 32'(conf_val), 32'd1);
        conf_rdy = 1'b1;

        // Abort at address 100; next grant must restart from bank 0.
        wait_addr(100, 300, "abort");
        d0 = done_cnt;
        req = '0;
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(wr_addr), 32'd0);
        req = 16'h0011;
        g0 = grant_cyc;
        for (int i = 0; i < 4 && grant_cyc == g0; i++) tick();
        check("abort_next_gnt", 32'(gnt_id), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        req = '0;
        wait_idle(700, "abort");

        // Beats gated by wr_val alternate; still exactly one burst.
        req = 16'h0020;
        n_wr_en = 0;
        g0 = grant_cyc;
        for (int i = 0; i < 4 && grant_cyc == g0; i++) tick();
        n_wr_en = 0;
        begin
            int start;
            int g;
            start = done_cnt;
            g = 0;
            while (done_cnt == start && g < 1200) begin
                wr_val = ~wr_val;
                tick();
                g++;
            end
        end
        check("toggle_wr_count", 32'(done_wr_cnt), 32'd512);
        req = '0; wr_val = 1'b1;
        wait_idle(10, "toggle");

        // Reset in the middle of a burst: no completion flagged.
        req = 16'h0040;
        wait_addr(50, 300, "rst_mid");
        d0 = done_cnt;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = '0;
        check("rst_mid_addr", 32'(wr_addr), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        check("rst_mid_no_done", 32'(done_cnt), 32'(d0));

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            req       = N'($urandom) & N'($urandom) & N'($urandom);
            req_en    = N'($urandom) | N'($urandom);
            conf_rdy  = ($urandom_range(0, 3) != 0);
            wr_val    = ($urandom_range(0, 9) < 7);
            cfg_start = ($urandom_range(0, 599) == 0);
            rst_n     = ($urandom_range(0, 1999) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
